// File: rtl/splat_credit_fifo_pkg.sv
// Shared splat constants and the per-write classification used by the
// credit accounting.
package splat_credit_fifo_pkg;

   localparam int SPLAT_DDR3_WIDTH = 64;
   localparam int SPLAT_MAX_BURST  = 8;
   localparam int SPLAT_DEPTH      = 32;

   // What happens to a word arriving on wr_en in a given cycle.
   typedef enum logic [1:0] {
      WR_IDLE,
      WR_STORE,
      WR_DRAIN,
      WR_DROP
   } wr_fate_e;

endpackage

// File: rtl/splat_credit_fifo_if.sv
// Reservation, write, read and status signals of the splat credit FIFO.
interface splat_credit_fifo_if
   import splat_credit_fifo_pkg::*;
#(
   parameter int WIDTH     = SPLAT_DDR3_WIDTH,
   parameter int DEPTH     = SPLAT_DEPTH,
   parameter int MAX_BURST = SPLAT_MAX_BURST
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(MAX_BURST + 1);

   logic             rsv_req;
   logic [LW-1:0]    rsv_len;
   logic             rsv_grant;
   logic [WIDTH-1:0] wr_data;
   logic             wr_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             rd_ack;
   logic [AW:0]      count;
   logic [AW:0]      space;
   logic             flush;
   logic             flush_busy;
   logic             overflow;

   modport master (
      output rsv_req, rsv_len, wr_data, wr_en, rd_ack, flush,
      input  rsv_grant, rd_data, rd_valid, count, space, flush_busy, overflow
   );

   modport slave (
      input  rsv_req, rsv_len, wr_data, wr_en, rd_ack, flush,
      output rsv_grant, rd_data, rd_valid, count, space, flush_busy, overflow
   );

endinterface

// File: rtl/splat_credit_ctr.sv
// Credit accounting: reserved-but-unwritten words, the post-flush drain
// of in-flight words, and the sticky overflow flag.
module splat_credit_ctr
   import splat_credit_fifo_pkg::*;
#(
   parameter int DEPTH     = SPLAT_DEPTH,
   parameter int MAX_BURST = SPLAT_MAX_BURST,
   localparam int AW = $clog2(DEPTH),
   localparam int PW = AW + 1,
   localparam int LW = $clog2(MAX_BURST + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          grant,
   input  logic [LW-1:0] grant_len,
   input  logic          wr_en,
   input  logic          flush,
   output logic [PW-1:0] outstanding,
   output logic          flush_busy,
   output logic          wr_store,
   output logic          overflow
);

   logic [PW-1:0] drain_cnt;
   logic [PW-1:0] grant_add;
   logic [PW-1:0] store_sub;
   logic [PW-1:0] drain_sub;
   wr_fate_e      fate;

   // A write during a drain is swallowed; a write racing a flush consumes
   // one of the credits that would otherwise become drain work.
   always_comb begin
      fate = WR_IDLE;
      if (wr_en) begin
         if (drain_cnt != '0)
            fate = WR_DRAIN;
         else if (outstanding != '0)
            fate = flush ? WR_DRAIN : WR_STORE;
         else
            fate = WR_DROP;
      end
   end

   assign grant_add  = grant ? PW'(grant_len) : '0;
   assign store_sub  = PW'(fate == WR_STORE);
   assign drain_sub  = PW'(fate == WR_DRAIN);
   assign wr_store   = (fate == WR_STORE);
   assign flush_busy = (drain_cnt != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding <= '0;
         drain_cnt   <= '0;
         overflow    <= 1'b0;
      end else begin
         if (flush) begin
            outstanding <= '0;
            drain_cnt   <= drain_cnt + outstanding - drain_sub;
         end else begin
            outstanding <= outstanding + grant_add - store_sub;
            drain_cnt   <= drain_cnt - drain_sub;
         end
         if (fate == WR_DROP)
            overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/splat_credit_fifo.sv
// Credit-reserved show-ahead FIFO for DDR3 read-return words; storage and
// pointers live here, credit bookkeeping in splat_credit_ctr.
module splat_credit_fifo
   import splat_credit_fifo_pkg::*;
#(
   parameter int WIDTH     = SPLAT_DDR3_WIDTH,
   parameter int DEPTH     = SPLAT_DEPTH,
   parameter int MAX_BURST = SPLAT_MAX_BURST
) (
   input logic                clk,
   input logic                reset,
   splat_credit_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = $clog2(MAX_BURST + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    count;
   logic [PW-1:0]    space;
   logic [PW-1:0]    outstanding;
   logic             rd_valid;
   logic             grant;
   logic             len_ok;
   logic             pop;
   logic             wr_store;
   logic             flush_busy;
   logic             overflow;

   assign count    = wr_ptr - rd_ptr;
   assign space    = PW'(DEPTH) - count - outstanding;
   assign rd_valid = (count != '0);
   assign len_ok   = (bus.rsv_len != '0) && (bus.rsv_len <= LW'(MAX_BURST));
   assign grant    = !reset && bus.rsv_req && len_ok && (PW'(bus.rsv_len) <= space)
                     && !bus.flush && !flush_busy;
   assign pop      = bus.rd_ack && rd_valid && !bus.flush;

   splat_credit_ctr #(
      .DEPTH     (DEPTH),
      .MAX_BURST (MAX_BURST)
   ) u_credit (
      .clk         (clk),
      .reset       (reset),
      .grant       (grant),
      .grant_len   (bus.rsv_len),
      .wr_en       (bus.wr_en),
      .flush       (bus.flush),
      .outstanding (outstanding),
      .flush_busy  (flush_busy),
      .wr_store    (wr_store),
      .overflow    (overflow)
   );

   // Pointers carry one extra bit so a full FIFO is distinguishable from empty.
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_store)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_store)
         mem[wr_ptr[AW-1:0]] <= bus.wr_data;
   end

   assign bus.rsv_grant  = grant;
   assign bus.rd_data    = mem[rd_ptr[AW-1:0]];
   assign bus.rd_valid   = rd_valid;
   assign bus.count      = count;
   assign bus.space      = space;
   assign bus.flush_busy = flush_busy;
   assign bus.overflow   = overflow;

endmodule

// File: tb/tb_splat_credit_fifo.sv
// Randomized and directed checks of splat_credit_fifo against a queue-based
// model of reservation credits, storage, drain and overflow.
module tb_splat_credit_fifo;

   localparam int WIDTH = 64;
   localparam int DEPTH = 32;
   localparam int MAXB  = 8;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   logic [WIDTH-1:0] mq[$];
   int               m_out = 0;
   int               m_drain = 0;
   bit               m_ovf = 1'b0;

   always #5 clk = ~clk;

   splat_credit_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAXB)) bus ();

   splat_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic int m_space();
      return DEPTH - mq.size() - m_out;
   endfunction

   function automatic bit m_grant();
      return !reset && bus.rsv_req && bus.rsv_len >= 1 && bus.rsv_len <= MAXB
             && int'(bus.rsv_len) <= m_space() && !bus.flush && m_drain == 0;
   endfunction

   task automatic set_idle();
      reset = 1'b0;
      bus.rsv_req = 1'b0;
      bus.rsv_len = '0;
      bus.wr_en = 1'b0;
      bus.wr_data = '0;
      bus.rd_ack = 1'b0;
      bus.flush = 1'b0;
   endtask

   // Clocks one edge and updates the model from the inputs held across it.
   task automatic advance();
      bit g;
      bit p;
      g = m_grant();
      p = bus.rd_ack && mq.size() > 0;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_out = 0;
         m_drain = 0;
         m_ovf = 1'b0;
      end else if (bus.flush) begin
         if (bus.wr_en && m_drain == 0 && m_out == 0) m_ovf = 1'b1;
         m_drain = m_drain + m_out - ((bus.wr_en && (m_drain > 0 || m_out > 0)) ? 1 : 0);
         m_out = 0;
         mq.delete();
      end else begin
         if (p) void'(mq.pop_front());
         if (bus.wr_en) begin
            if (m_drain > 0) m_drain--;
            else if (m_out > 0) begin
               mq.push_back(bus.wr_data);
               m_out--;
            end else m_ovf = 1'b1;
         end
         if (g) m_out += int'(bus.rsv_len);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1'b1;
      bus.rsv_req = 1'b1;
      bus.rsv_len = 1;
      #1;
      vectors++;
      if (bus.rsv_grant !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_grant: got %b expected 0", bus.rsv_grant);
      end
      advance();
      set_idle();
      #1;
      vectors++;
      if (bus.count !== 0 || bus.space !== DEPTH || bus.rd_valid !== 1'b0 ||
          bus.flush_busy !== 1'b0 || bus.overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: count=%0d space=%0d valid=%b busy=%b ovf=%b expected 0/%0d/0/0/0",
                  bus.count, bus.space, bus.rd_valid, bus.flush_busy, bus.overflow, DEPTH);
      end
   endtask

   task automatic test_burst_order();
      logic [WIDTH-1:0] a [8];
      set_idle();
      bus.rsv_req = 1'b1;
      bus.rsv_len = 8;
      #1;
      vectors++;
      if (bus.rsv_grant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL burst_grant: got %b expected 1", bus.rsv_grant);
      end
      advance();
      bus.rsv_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a[i] = {$urandom, $urandom};
         bus.wr_en = 1'b1;
         bus.wr_data = a[i];
         #1;
         if (i == 0) begin
            vectors++;
            if (bus.rd_valid !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL no_bypass: rd_valid got %b expected 0", bus.rd_valid);
            end
         end
         advance();
      end
      bus.wr_en = 1'b0;
      #1;
      vectors++;
      if (bus.count !== 8 || bus.space !== 24) begin
         miscompares++;
         $display("[TB] FAIL burst_fill: count=%0d space=%0d expected 8/24", bus.count, bus.space);
      end
      bus.rd_ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         vectors++;
         if (bus.rd_data !== a[i] || bus.count !== 8 - i) begin
            miscompares++;
            $display("[TB] FAIL burst_pop[%0d]: data=%h count=%0d expected %h/%0d",
                     i, bus.rd_data, bus.count, a[i], 8 - i);
         end
         advance();
      end
      bus.rd_ack = 1'b0;
      #1;
      vectors++;
      if (bus.count !== 0 || bus.space !== DEPTH) begin
         miscompares++;
         $display("[TB] FAIL burst_empty: count=%0d space=%0d expected 0/%0d", bus.count, bus.space, DEPTH);
      end
   endtask

   task automatic test_space_block();
      set_idle();
      for (int k = 0; k < 4; k++) begin
         bus.rsv_req = 1'b1;
         bus.rsv_len = 8;
         advance();
      end
      bus.rsv_len = 1;
      #1;
      vectors++;
      if (bus.rsv_grant !== 1'b0 || bus.space !== 0) begin
         miscompares++;
         $display("[TB] FAIL block_grant: grant=%b space=%0d expected 0/0", bus.rsv_grant, bus.space);
      end
      bus.rsv_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_data = {$urandom, $urandom};
         advance();
      end
      bus.wr_en = 1'b0;
      bus.rsv_req = 1'b1;
      bus.rd_ack = 1'b1;
      #1;
      vectors++;
      if (bus.rsv_grant !== 1'b0 || bus.count !== DEPTH || bus.rd_data !== mq[0]) begin
         miscompares++;
         $display("[TB] FAIL full_block: grant=%b count=%0d data=%h expected 0/%0d/%h",
                  bus.rsv_grant, bus.count, bus.rd_data, DEPTH, mq[0]);
      end
      advance();
      bus.rd_ack = 1'b0;
      #1;
      vectors++;
      if (bus.rsv_grant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL grant_after_pop: got %b expected 1", bus.rsv_grant);
      end
      advance();
      bus.rsv_req = 1'b0;
      bus.wr_en = 1'b1;
      bus.wr_data = {$urandom, $urandom};
      advance();
      bus.wr_en = 1'b0;
      bus.rd_ack = 1'b1;
      for (int i = 0; i < DEPTH + 2 && mq.size() > 0; i++) begin
         #1;
         vectors++;
         if (bus.rd_data !== mq[0]) begin
            miscompares++;
            $display("[TB] FAIL block_drain[%0d]: got %h expected %h", i, bus.rd_data, mq[0]);
         end
         advance();
      end
      bus.rd_ack = 1'b0;
      #1;
      vectors++;
      if (bus.count !== 0 || bus.space !== DEPTH) begin
         miscompares++;
         $display("[TB] FAIL block_empty: count=%0d space=%0d expected 0/%0d", bus.count, bus.space, DEPTH);
      end
   endtask

   task automatic test_overflow();
      set_idle();
      bus.wr_en = 1'b1;
      bus.wr_data = {$urandom, $urandom};
      advance();
      bus.wr_en = 1'b0;
      #1;
      vectors++;
      if (bus.count !== 0 || bus.overflow !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL overflow_set: count=%0d ovf=%b expected 0/1", bus.count, bus.overflow);
      end
      for (int i = 0; i < 3; i++) advance();
      vectors++;
      if (bus.overflow !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL overflow_sticky: got %b expected 1", bus.overflow);
      end
      reset = 1'b1;
      advance();
      reset = 1'b0;
      #1;
      vectors++;
      if (bus.overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL overflow_clear: got %b expected 0", bus.overflow);
      end
   endtask

   task automatic test_flush_drain();
      set_idle();
      bus.rsv_req = 1'b1;
      bus.rsv_len = 8;
      advance();
      bus.rsv_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_data = {$urandom, $urandom};
         advance();
      end
      bus.wr_en = 1'b0;
      bus.flush = 1'b1;
      bus.rsv_req = 1'b1;
      bus.rsv_len = 1;
      #1;
      vectors++;
      if (bus.rsv_grant !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_grant: got %b expected 0", bus.rsv_grant);
      end
      advance();
      bus.flush = 1'b0;
      #1;
      vectors++;
      if (bus.count !== 0 || bus.flush_busy !== 1'b1 || bus.rd_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_state: count=%0d busy=%b valid=%b expected 0/1/0",
                  bus.count, bus.flush_busy, bus.rd_valid);
      end
      for (int i = 0; i < 5; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_data = {$urandom, $urandom};
         #1;
         vectors++;
         if (bus.rsv_grant !== 1'b0 || bus.flush_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drain[%0d]: grant=%b busy=%b expected 0/1", i, bus.rsv_grant, bus.flush_busy);
         end
         advance();
      end
      bus.wr_en = 1'b0;
      #1;
      vectors++;
      if (bus.flush_busy !== 1'b0 || bus.count !== 0 || bus.space !== DEPTH ||
          bus.rsv_grant !== 1'b1 || bus.overflow !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL drain_done: busy=%b count=%0d space=%0d grant=%b ovf=%b expected 0/0/%0d/1/0",
                  bus.flush_busy, bus.count, bus.space, bus.rsv_grant, bus.overflow, DEPTH);
      end
      bus.rsv_req = 1'b0;
   endtask

   task automatic test_wrap_stream();
      int lens [4] = '{8, 8, 8, 6};
      set_idle();
      for (int k = 0; k < 4; k++) begin
         bus.rsv_req = 1'b1;
         bus.rsv_len = lens[k][3:0];
         advance();
      end
      bus.rsv_req = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_data = {$urandom, $urandom};
         advance();
      end
      bus.wr_en = 1'b0;
      bus.rsv_req = 1'b1;
      bus.rsv_len = 1;
      bus.rd_ack = 1'b1;
      advance();
      for (int i = 0; i < 100; i++) begin
         bus.wr_en = 1'b1;
         bus.wr_data = {$urandom, $urandom};
         #1;
         vectors++;
         if (bus.count !== 29 || bus.rsv_grant !== 1'b1 || bus.rd_data !== mq[0]) begin
            miscompares++;
            $display("[TB] FAIL stream[%0d]: count=%0d grant=%b data=%h expected 29/1/%h",
                     i, bus.count, bus.rsv_grant, bus.rd_data, mq[0]);
         end
         advance();
      end
      bus.rsv_req = 1'b0;
      bus.rd_ack = 1'b0;
      bus.wr_data = {$urandom, $urandom};
      advance();
      bus.wr_en = 1'b0;
      bus.rd_ack = 1'b1;
      for (int i = 0; i < DEPTH + 2 && mq.size() > 0; i++) begin
         #1;
         vectors++;
         if (bus.rd_data !== mq[0]) begin
            miscompares++;
            $display("[TB] FAIL stream_drain[%0d]: got %h expected %h", i, bus.rd_data, mq[0]);
         end
         advance();
      end
      bus.rd_ack = 1'b0;
      #1;
      vectors++;
      if (bus.count !== 0 || bus.space !== DEPTH) begin
         miscompares++;
         $display("[TB] FAIL stream_empty: count=%0d space=%0d expected 0/%0d", bus.count, bus.space, DEPTH);
      end
   endtask

   task automatic test_same_cycle();
      set_idle();
      bus.rsv_req = 1'b1;
      bus.rsv_len = 2;
      advance();
      bus.rsv_len = 4;
      bus.wr_en = 1'b1;
      bus.wr_data = {$urandom, $urandom};
      #1;
      vectors++;
      if (bus.rsv_grant !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL same_cycle_grant: got %b expected 1", bus.rsv_grant);
      end
      advance();
      set_idle();
      #1;
      vectors++;
      if (bus.count !== 1 || bus.space !== 26) begin
         miscompares++;
         $display("[TB] FAIL same_cycle_credit: count=%0d space=%0d expected 1/26", bus.count, bus.space);
      end
      reset = 1'b1;
      advance();
      reset = 1'b0;
   endtask

   task automatic test_random();
      bit eg;
      set_idle();
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         bus.flush = ($urandom_range(0, 39) == 0);
         bus.rsv_req = ($urandom_range(0, 2) == 0);
         bus.rsv_len = 4'($urandom_range(0, 10));
         bus.wr_en = (m_out > 0 || m_drain > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
         bus.wr_data = {$urandom, $urandom};
         bus.rd_ack = ($urandom_range(0, 2) == 0);
         #1;
         eg = m_grant();
         vectors++;
         if (bus.rsv_grant !== eg || bus.count !== mq.size() || bus.space !== m_space() ||
             bus.rd_valid !== (mq.size() > 0) || bus.flush_busy !== (m_drain != 0) ||
             bus.overflow !== m_ovf || (mq.size() > 0 && bus.rd_data !== mq[0])) begin
            miscompares++;
            $display("[TB] FAIL random[%0d]: grant=%b count=%0d space=%0d busy=%b ovf=%b data=%h expected %b/%0d/%0d/%b/%b/%h",
                     i, bus.rsv_grant, bus.count, bus.space, bus.flush_busy, bus.overflow, bus.rd_data,
                     eg, mq.size(), m_space(), m_drain != 0, m_ovf, (mq.size() > 0) ? mq[0] : '0);
         end
         advance();
      end
   endtask

   initial begin
      set_idle();
      reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_burst_order();
      test_space_block();
      test_overflow();
      test_flush_drain();
      test_wrap_stream();
      test_same_cycle();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
